// File: rtl/exmem_arbiter.sv
// exmem_arbiter: two-master Wishbone-classic arbiter in front of a fixed-latency memory pipeline.
// Round-robin by default; define EXMEM_ARB_FIXED_PRIO_EN for fixed priority (master 0 wins ties).
module exmem_arbiter #(
    parameter int MEM_LAT = 11
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic [3:0]  m0_sel,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_dat_i,
    output logic        m0_ack,
    output logic [31:0] m0_dat_o,

    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic [3:0]  m1_sel,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_dat_i,
    output logic        m1_ack,
    output logic [31:0] m1_dat_o,

    output logic        mem_stb,
    output logic        mem_we,
    output logic [3:0]  mem_sel,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_dat_o,
    input  logic        mem_ack,
    input  logic [31:0] mem_dat_i,

    output logic [1:0]  outstanding,
    output logic        err_lat
);

    // Handshake: a master holds stb (and its fields) high until it sees a one-cycle ack, then
    // drops stb at that same edge. The memory takes every one-cycle mem_stb (no backpressure)
    // and returns exactly one mem_ack per strobe, in order, MEM_LAT cycles later.

    localparam int AGE_W = $clog2(MEM_LAT + 4);
    localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(MEM_LAT + 2);
    localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

    logic [1:0]       inflight_q, inflight_d;
    logic             mem_stb_q, mem_stb_d;
    logic             mem_we_q, mem_we_d;
    logic [3:0]       mem_sel_q, mem_sel_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_dat_q, mem_dat_d;
    logic [1:0]       tag_q, tag_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             m0_ack_q, m0_ack_d;
    logic             m1_ack_q, m1_ack_d;
    logic [31:0]      m0_dat_q, m0_dat_d;
    logic [31:0]      m1_dat_q, m1_dat_d;
    logic [AGE_W-1:0] age_q, age_d;
    logic             err_lat_q, err_lat_d;
`ifndef EXMEM_ARB_FIXED_PRIO_EN
    logic             last_grant_q, last_grant_d;
`endif

    logic [1:0] eligible;
    logic       issue;
    logic       winner;
    logic       pop;
    logic       head;

    always_comb begin
        eligible = {m1_stb & ~inflight_q[1], m0_stb & ~inflight_q[0]};
        issue    = |eligible;
`ifdef EXMEM_ARB_FIXED_PRIO_EN
        winner = ~eligible[0];
`else
        // On a tie the master that did not win the previous issue goes next.
        winner = (eligible == 2'b11) ? ~last_grant_q : eligible[1];
`endif
        head = tag_q[rd_ptr_q];
        // An ack with nothing in flight is an error, not a return.
        pop  = mem_ack & (count_q != 2'd0);
    end

    always_comb begin
        mem_stb_d  = issue;
        mem_we_d   = mem_we_q;
        mem_sel_d  = mem_sel_q;
        mem_addr_d = mem_addr_q;
        mem_dat_d  = mem_dat_q;
        if (issue) begin
            mem_we_d   = winner ? m1_we    : m0_we;
            mem_sel_d  = winner ? m1_sel   : m0_sel;
            mem_addr_d = winner ? m1_addr  : m0_addr;
            mem_dat_d  = winner ? m1_dat_i : m0_dat_i;
        end
    end

    always_comb begin
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (issue) begin
            tag_d[wr_ptr_q] = winner;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({issue, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q;
        if (m0_ack_q) inflight_d[0] = 1'b0;
        if (m1_ack_q) inflight_d[1] = 1'b0;
        if (issue)    inflight_d[winner] = 1'b1;

        m0_ack_d = pop & ~head;
        m1_ack_d = pop & head;
        m0_dat_d = m0_ack_d ? mem_dat_i : m0_dat_q;
        m1_dat_d = m1_ack_d ? mem_dat_i : m1_dat_q;
    end

`ifndef EXMEM_ARB_FIXED_PRIO_EN
    always_comb begin
        last_grant_d = issue ? winner : last_grant_q;
    end
`endif

    // Age restarts whenever a new head becomes the oldest request; it saturates rather than wraps.
    always_comb begin
        age_d = age_q;
        if (pop || (issue && count_q == 2'd0)) begin
            age_d = '0;
        end else if (count_q != 2'd0 && age_q != AGE_MAX) begin
            age_d = age_q + AGE_W'(1);
        end
        err_lat_d = err_lat_q
                  | (mem_ack && count_q == 2'd0)
                  | (age_d > AGE_LIM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= '0;
            mem_stb_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_sel_q  <= '0;
            mem_addr_q <= '0;
            mem_dat_q  <= '0;
            tag_q      <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= '0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_dat_q   <= '0;
            m1_dat_q   <= '0;
            age_q      <= '0;
            err_lat_q  <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            mem_stb_q  <= mem_stb_d;
            mem_we_q   <= mem_we_d;
            mem_sel_q  <= mem_sel_d;
            mem_addr_q <= mem_addr_d;
            mem_dat_q  <= mem_dat_d;
            tag_q      <= tag_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
            m0_dat_q   <= m0_dat_d;
            m1_dat_q   <= m1_dat_d;
            age_q      <= age_d;
            err_lat_q  <= err_lat_d;
        end
    end

`ifndef EXMEM_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign m0_ack      = m0_ack_q;
    assign m1_ack      = m1_ack_q;
    assign m0_dat_o    = m0_dat_q;
    assign m1_dat_o    = m1_dat_q;
    assign mem_stb     = mem_stb_q;
    assign mem_we      = mem_we_q;
    assign mem_sel     = mem_sel_q;
    assign mem_addr    = mem_addr_q;
    assign mem_dat_o   = mem_dat_q;
    assign outstanding = count_q;
    assign err_lat     = err_lat_q;

endmodule

// File: tb/tb_exmem_arbiter.sv
// tb_exmem_arbiter: directed and random checks of exmem_arbiter against a transaction-level model,
// with a fixed-latency BRAM pipeline model standing in for the memory.
`timescale 1ns/1ps
module tb_exmem_arbiter;
    localparam int MEM_LAT = 11;
    localparam int LAT_M   = MEM_LAT + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- master-side stimulus ----------------
    logic [1:0]  m_stb = '0;
    logic [1:0]  m_we  = '0;
    logic [3:0]  m_sel [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_dat [2];

    logic        m0_ack, m1_ack;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        mem_stb, mem_we, mem_ack;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr, mem_dat_o, mem_dat_i;
    logic [1:0]  outstanding;
    logic        err_lat;

    exmem_arbiter #(.MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst(rst),
        .m0_stb(m_stb[0]), .m0_we(m_we[0]), .m0_sel(m_sel[0]), .m0_addr(m_addr[0]),
        .m0_dat_i(m_dat[0]), .m0_ack(m0_ack), .m0_dat_o(m0_dat_o),
        .m1_stb(m_stb[1]), .m1_we(m_we[1]), .m1_sel(m_sel[1]), .m1_addr(m_addr[1]),
        .m1_dat_i(m_dat[1]), .m1_ack(m1_ack), .m1_dat_o(m1_dat_o),
        .mem_stb(mem_stb), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_dat_o(mem_dat_o), .mem_ack(mem_ack), .mem_dat_i(mem_dat_i),
        .outstanding(outstanding), .err_lat(err_lat)
    );

    // ---------------- memory environment: MEM_LAT-cycle pipeline ----------------
    bit [31:0]          mem_arr [256];
    logic [MEM_LAT-1:0] pv;
    logic [31:0]        pd [MEM_LAT];
    logic [31:0]        env_w;
    bit                 mem_force = 1'b0;
    bit                 mem_suppress = 1'b0;

    always_comb begin
        env_w = mem_arr[mem_addr[9:2]];
        for (int b = 0; b < 4; b++) begin
            if (mem_we && mem_sel[b]) env_w[8*b +: 8] = mem_dat_o[8*b +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv <= '0;
        end else begin
            pv <= {pv[MEM_LAT-2:0], mem_stb};
            for (int i = MEM_LAT - 1; i > 0; i--) pd[i] <= pd[i-1];
            if (mem_stb) begin
                mem_arr[mem_addr[9:2]] <= env_w;
                pd[0] <= env_w;
            end
        end
    end

    assign mem_ack   = (pv[MEM_LAT-1] & ~mem_suppress) | mem_force;
    assign mem_dat_i = pd[MEM_LAT-1];

    // ---------------- reference model / scoreboard ----------------
    typedef struct packed {
        logic        id;
        logic        lost;
        logic [31:0] data;
        int          due;
        int          issue;
    } txn_t;

    txn_t        exp_q[$];
    bit [31:0]   ref_mem [256];
    int          cyc = 0;
    logic [1:0]  busy, rel_pend;
    int          rel_at [2];
    logic        last_g;
    logic        exp_stb, exp_we, exp_err;
    logic [3:0]  exp_sel;
    logic [31:0] exp_addr, exp_wdat;
    logic [1:0]  exp_ack;
    logic [31:0] exp_dat [2];

    int n_assert = 0;
    int n_fail   = 0;
    int ack_cnt [2];
    int last_ack_cyc [2];
    int err_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        busy = '0; rel_pend = '0; last_g = 1'b1;
        exp_stb = 1'b0; exp_we = 1'b0; exp_sel = '0; exp_addr = '0; exp_wdat = '0;
        exp_ack = '0; exp_dat[0] = '0; exp_dat[1] = '0; exp_err = 1'b0;
    endtask

    // One clock: advance the model at the edge, compare everything at the following negedge.
    task automatic tick();
        logic [1:0]  elig;
        int          w;
        int          idx;
        logic [31:0] word;
        txn_t        t;
        @(posedge clk);
        cyc++;
        elig = m_stb & ~busy;
        for (int k = 0; k < 2; k++) begin
            if (rel_pend[k] && rel_at[k] == cyc) begin
                busy[k] = 1'b0;
                rel_pend[k] = 1'b0;
            end
        end
        exp_ack = '0;
        if (mem_force && exp_q.size() == 0) exp_err = 1'b1;
        if (exp_q.size() > 0 && !exp_q[0].lost && exp_q[0].due == cyc) begin
            t = exp_q.pop_front();
            exp_ack[t.id] = 1'b1;
            exp_dat[t.id] = t.data;
            rel_pend[t.id] = 1'b1;
            rel_at[t.id] = cyc + 1;
        end
        if (exp_q.size() > 0 && exp_q[0].lost && cyc == exp_q[0].issue + MEM_LAT + 3) exp_err = 1'b1;
        exp_stb = 1'b0;
        if (elig != 2'b00) begin
            if (elig == 2'b01) w = 0;
            else if (elig == 2'b10) w = 1;
`ifdef EXMEM_ARB_FIXED_PRIO_EN
            else w = 0;
`else
            else w = (last_g == 1'b0) ? 1 : 0;
`endif
            idx  = int'(m_addr[w][9:2]);
            word = ref_mem[idx];
            if (m_we[w]) begin
                for (int b = 0; b < 4; b++) if (m_sel[w][b]) word[8*b +: 8] = m_dat[w][8*b +: 8];
            end
            ref_mem[idx] = word;
            t.id = w[0]; t.lost = mem_suppress; t.data = word;
            t.due = cyc + MEM_LAT + 1; t.issue = cyc;
            exp_q.push_back(t);
            busy[w] = 1'b1;
            last_g  = w[0];
            exp_stb = 1'b1; exp_we = m_we[w]; exp_sel = m_sel[w];
            exp_addr = m_addr[w]; exp_wdat = m_dat[w];
        end
        @(negedge clk);
        chk("mem_stb", mem_stb, exp_stb);
        chk("mem_we", mem_we, exp_we);
        chk("mem_sel", mem_sel, exp_sel);
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_dat_o", mem_dat_o, exp_wdat);
        chk("m0_ack", m0_ack, exp_ack[0]);
        chk("m1_ack", m1_ack, exp_ack[1]);
        chk("m0_dat_o", m0_dat_o, exp_dat[0]);
        chk("m1_dat_o", m1_dat_o, exp_dat[1]);
        chk("outstanding", outstanding, exp_q.size());
        chk("err_lat", err_lat, exp_err);
        if (m0_ack === 1'b1) begin ack_cnt[0]++; last_ack_cyc[0] = cyc; end
        if (m1_ack === 1'b1) begin ack_cnt[1]++; last_ack_cyc[1] = cyc; end
        if (err_lat === 1'b1 && err_seen < 0) err_seen = cyc;
        for (int k = 0; k < 2; k++) if (exp_ack[k]) m_stb[k] = 1'b0;
    endtask

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic raise(input int k, input logic we, input logic [3:0] sel,
                         input logic [31:0] addr, input logic [31:0] dat);
        m_stb[k] = 1'b1; m_we[k] = we; m_sel[k] = sel; m_addr[k] = addr; m_dat[k] = dat;
    endtask

    task automatic do_reset(input bit check_now);
        rst = 1'b1;
        m_stb = '0;
        #1;
        if (check_now) begin
            chk("rst_mem_stb", mem_stb, 0);
            chk("rst_mem_fields", {mem_we, mem_sel, mem_addr[26:0]}, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_dat_o", mem_dat_o, 0);
            chk("rst_acks", {m0_ack, m1_ack}, 0);
            chk("rst_m0_dat_o", m0_dat_o, 0);
            chk("rst_m1_dat_o", m1_dat_o, 0);
            chk("rst_outstanding", outstanding, 0);
            chk("rst_err_lat", err_lat, 0);
        end
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mem_suppress = 1'b0;
        mem_force = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while ((m_stb != 2'b00 || busy != 2'b00 || exp_q.size() != 0) && n < max_cyc) begin
            tick();
            n++;
        end
        chk("idle_within_budget", (n < max_cyc) ? 1 : 0, 1);
        tick();
    endtask

`ifdef EXMEM_ARB_FIXED_PRIO_EN
    localparam bit [2:0] FIRST_TBL = 3'b000;
`else
    localparam bit [2:0] FIRST_TBL = 3'b010;
`endif
    localparam bit [2:0] PRE_TBL = 3'b101;

    // ---------------- directed sequence ----------------
    initial begin
        int req_cyc;
        int iss;
        for (int k = 0; k < 2; k++) begin
            m_sel[k] = '0; m_addr[k] = '0; m_dat[k] = '0;
            ack_cnt[k] = 0; last_ack_cyc[k] = -1000; rel_at[k] = 0;
        end
        err_seen = -1;
        model_clear();
        @(negedge clk);
        do_reset(1'b1);

        // Single write then read by master 0
        raise(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        req_cyc = cyc + 1;
        wait_idle(40);
        chk("m0_wr_latency", last_ack_cyc[0] - req_cyc, LAT_M);
        raise(0, 1'b0, 4'hF, 32'h10, 32'h0);
        req_cyc = cyc + 1;
        wait_idle(40);
        chk("m0_rd_latency", last_ack_cyc[0] - req_cyc, LAT_M);
        chk("m0_rd_data", m0_dat_o, 32'hDEADBEEF);
        chk("m1_quiet", ack_cnt[1], 0);

        // Seed 0x4 / 0x8, then simultaneous reads straight after reset
        raise(0, 1'b1, 4'hF, 32'h4, 32'h0404CAFE);
        wait_idle(40);
        raise(1, 1'b1, 4'hF, 32'h8, 32'h0808BEEF);
        wait_idle(40);
        do_reset(1'b0);
        raise(0, 1'b0, 4'hF, 32'h4, 32'h0);
        raise(1, 1'b0, 4'hF, 32'h8, 32'h0);
        tick();
        chk("tie_first_addr", mem_addr, 32'h4);
        tick();
        chk("tie_second_stb", mem_stb, 1);
        chk("tie_second_addr", mem_addr, 32'h8);
        wait_idle(40);
        chk("tie_m0_data", m0_dat_o, 32'h0404CAFE);
        chk("tie_m1_data", m1_dat_o, 32'h0808BEEF);
        chk("tie_ack_spacing", last_ack_cyc[1] - last_ack_cyc[0], 1);

        // Contention rounds, each preceded by a solo request from one master
        for (int r = 0; r < 3; r++) begin
            raise(PRE_TBL[r] ? 1 : 0, 1'b0, 4'hF, 32'h100, 32'h0);
            wait_idle(40);
            raise(0, 1'b0, 4'hF, 32'h40, 32'h0);
            raise(1, 1'b0, 4'hF, 32'h80, 32'h0);
            tick();
            chk("round_first", mem_addr, FIRST_TBL[r] ? 32'h80 : 32'h40);
            wait_idle(40);
        end

        // Byte-lane write by master 1
        raise(1, 1'b1, 4'hF, 32'h20, 32'h11223344);
        wait_idle(40);
        raise(1, 1'b1, 4'b0010, 32'h20, 32'h0000AB00);
        wait_idle(40);
        raise(1, 1'b0, 4'hF, 32'h20, 32'h0);
        wait_idle(40);
        chk("byte_merge", m1_dat_o, 32'h1122AB44);

        // Random traffic from both masters
        for (int c = 0; c < 500; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!m_stb[k] && !busy[k] && $urandom_range(0, 2) == 0) begin
                    raise(k, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          {22'b0, 8'($urandom_range(0, 63)), 2'b00}, $urandom);
                end
            end
            tick();
        end
        wait_idle(60);

        // Reset five cycles after issue
        ack_cnt[0] = 0; ack_cnt[1] = 0;
        raise(0, 1'b0, 4'hF, 32'h10, 32'h0);
        tick();
        repeat (5) tick();
        do_reset(1'b1);
        repeat (30) tick();
        chk("midrst_no_m0_ack", ack_cnt[0], 0);
        chk("midrst_no_m1_ack", ack_cnt[1], 0);

        // Spurious ack with nothing in flight
        mem_force = 1'b1;
        tick();
        mem_force = 1'b0;
        chk("spurious_err", err_lat, 1);
        repeat (10) tick();
        chk("spurious_err_sticky", err_lat, 1);
        chk("spurious_no_acks", ack_cnt[0] + ack_cnt[1], 0);
        do_reset(1'b1);

        // Missing ack
        mem_suppress = 1'b1;
        err_seen = -1;
        raise(0, 1'b0, 4'hF, 32'h10, 32'h0);
        tick();
        iss = cyc;
        repeat (MEM_LAT + 8) tick();
        chk("missing_ack_err_delay", err_seen - iss, MEM_LAT + 3);
        do_reset(1'b1);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: observed no end of test, expected finish before 1 ms");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/exmem_arbiter.md
# exmem_arbiter

Two-master arbiter placed in front of the pipelined user-area memory (fixed-latency, no-backpressure BRAM pipeline). It accepts Wishbone-classic requests from master 0 (management SoC Wishbone) and master 1 (user-side engine). It issues at most one single-cycle strobe per clock to the memory and steers each in-order memory ack/data back to the master that owns it. Arbitration is round-robin, or fixed priority when configured. A built-in latency watchdog flags acks that are missing or unexpected.

## Interface
- MEM_LAT, 11: expected cycles from memory strobe cycle to memory ack cycle.
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- m0_stb, m1_stb  in  1  request; held high until that master's ack.
- m0_we, m1_we  in  1  1 = write, 0 = read.
- m0_sel, m1_sel  in  4  byte enables.
- m0_addr, m1_addr  in  32  address.
- m0_dat_i, m1_dat_i  in  32  write data.
- m0_ack, m1_ack  out  1  one-cycle completion pulse.
- m0_dat_o, m1_dat_o  out  32  read data; valid while the matching ack is high.
- mem_stb  out  1  one-cycle request to the memory.
- mem_we, mem_sel, mem_addr, mem_dat_o  out  1/4/32/32  request fields to the memory.
- mem_ack  in  1  memory completion.
- mem_dat_i  in  32  memory read data.
- outstanding  out  2  number of in-flight requests (0..2).
- err_lat  out  1  sticky: an ack was missing for more than MEM_LAT+2 cycles, or an ack arrived with nothing in flight.

## Operation
- Per-master flag inflight_k. eligible_k = mk_stb & ~inflight_k.
- Issue, on each clk edge:
  - If any master is eligible, pick a winner and register its fields onto mem_*.
  - Assert mem_stb for the next cycle only, set inflight_winner, and push the winner ID into a 2-entry tag FIFO.
  - If no master is eligible, mem_stb <= 0 and mem_* fields hold their previous values.
- Round-robin: last_grant register. With both masters eligible, the master not in last_grant wins. A single eligible master always wins. last_grant updates on every issue.
- Return:
  - On mem_ack: pop the tag FIFO head h; register mh_ack <= 1 and mh_dat_o <= mem_dat_i.
  - The other master's ack stays 0; its dat_o holds its previous value.
- Release: at the edge where mk_ack is high, clear inflight_k. The master drops stb at that same edge, so it is never re-issued.
- outstanding = tag FIFO count. Push and pop in the same cycle leave the count unchanged. A push never occurs when the count is 2, because both inflight flags are then set.
- Watchdog:
  - Counter age resets on every pop and every push into an empty FIFO.
  - It counts while outstanding != 0. age > MEM_LAT+2 sets err_lat.
  - mem_ack with outstanding == 0 sets err_lat and generates no master ack.
  - err_lat clears only on rst.
- Reset values: all outputs 0, inflight 0, FIFO empty, last_grant = 1 (so master 0 wins the first tie), age 0.
- Reset mid-transaction drops everything. The memory shares rst, so no stale acks arrive afterwards.

## Timing
- mk_stb sampled high at edge E (idle arbiter):
  - mem_stb high in cycle E..E+1.
  - mem_ack high after edge E+1+MEM_LAT-1.
  - mk_ack high after edge E+MEM_LAT+1, for one cycle.
  - inflight cleared at the next edge.
- Master-visible latency = MEM_LAT+1 edges (12 with the default).
- Two masters requesting simultaneously: mem_stb is high for two consecutive cycles (winner, then loser). The acks return in the same order, one cycle apart.
- Per-master repeat rate: one transaction per MEM_LAT+3 cycles. The memory may carry both masters' requests concurrently.

## Configuration
- EXMEM_ARB_FIXED_PRIO_EN defined: master 0 always wins ties; last_grant is not used for selection.
- Undefined: round-robin as described.

## Test plan
- Single read, master 0:
  - Stimulus: write 0xDEADBEEF to 0x10 via m0, then read 0x10.
  - Required: m0_ack 12 cycles after each stb sample; m0_dat_o = 0xDEADBEEF; m1_ack stays 0.
- Simultaneous requests after reset:
  - Stimulus: m0 reads 0x4, m1 reads 0x8.
  - Required: mem_stb two back-to-back cycles, m0 first; m0_ack then m1_ack on consecutive cycles with the correct data.
- Continuous contention, both stb always re-raised:
  - Required (round-robin): the first issue of each round alternates m0, m1, m0.
  - Required (fixed-priority build): m0 always issues first.
- Byte writes:
  - Stimulus: m1 writes sel = 4'b0010, data 0x0000AB00 over 0x11223344.
  - Required: a read returns 0x1122AB44.
- Reset mid-flight:
  - Stimulus: assert rst 5 cycles after issue.
  - Required: all outputs 0 immediately; no m0_ack/m1_ack ever pulses for that request.
- Error injection:
  - Stimulus: force mem_ack with outstanding = 0.
  - Required: err_lat = 1, stays 1 until rst, no master ack.
  - Stimulus: suppress mem_ack.
  - Required: err_lat sets MEM_LAT+3 cycles after issue.
